// File: rtl/jk_sync_counter_pkg.sv
// Package: jk_sync_counter_pkg
// Purpose : Shared {J,K} excitation encoding used by the counter
//           next-state logic and by every jk_cell instance, plus the
//           JK flip-flop characteristic function.
// Contents:
//   jk_op_e       {J,K} encoding: HOLD=00, RST=01, SET=10, TGL=11
//   jk_next()     next Q of one JK flip-flop given {J,K} and present Q
package jk_sync_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input jk_op_e op, input logic q);
    logic nq;
    nq = q;
    case (op)
      JK_HOLD: nq = q;
      JK_RST:  nq = 1'b0;
      JK_SET:  nq = 1'b1;
      JK_TGL:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Module : jk_cell
// Purpose: One JK flip-flop with synchronous active-low reset.
// Ports  :
//   clk    in  1  clock, state updates on posedge
//   reset  in  1  synchronous active-low reset, forces q to 0
//   j      in  1  J excitation
//   k      in  1  K excitation
//   q      out 1  flip-flop state
module jk_cell
  import jk_sync_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  logic   q_q;
  logic   q_d;
  jk_op_e op;

  always_comb begin
    op  = jk_op_e'({j, k});
    q_d = jk_next(op, q_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Module : jk_sync_counter
// Purpose: Synchronous mod-MODULUS up/down counter whose state lives in a
//          bank of jk_cell flip-flops. This block computes the per-bit J/K
//          excitation and a registered terminal-count pulse.
// Params :
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1 (2..2**WIDTH)
// Ports  :
//   clk     in  1      clock, all updates on posedge
//   reset   in  1      synchronous active-low reset
//   en      in  1      count enable
//   up      in  1      1 = count up, 0 = count down
//   load    in  1      parallel load request (beats en)
//   din     in  WIDTH  load value; values >= MODULUS load 0
//   q       out WIDTH  counter state (jk_cell outputs)
//   tc      out 1      one-cycle pulse after a wrapping count edge
//   j_vec   out WIDTH  J excitation presented to the cells
//   k_vec   out WIDTH  K excitation presented to the cells
module jk_sync_counter
  import jk_sync_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] tgl;
  logic             wrap;
  logic             tc_q;
  logic             tc_d;

  // Out-of-range load values collapse to 0 so the state never leaves
  // the legal range; the excitation must follow the clamped value.
  assign load_val = (32'(din) < MODULUS) ? din : '0;

  always_comb begin
    cnt_nxt = q;
    wrap    = 1'b0;
    if (up) begin
      if (q == MAX_Q) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        cnt_nxt = MAX_Q;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = q - WIDTH'(1);
      end
    end
  end

  // Bits that differ between present and next count get J=K=1 (toggle),
  // the rest J=K=0 (hold).
  assign tgl = q ^ cnt_nxt;

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    tc_d  = 1'b0;
    if (load) begin
      j_vec = load_val;
      k_vec = ~load_val;
    end else if (en) begin
      j_vec = tgl;
      k_vec = tgl;
      tc_d  = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;

  generate
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j     (j_vec[gi]),
        .k     (k_vec[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

endmodule
